// File: rtl/rect_plotter_if.sv
// rtl/rect_plotter_if.sv - command/pixel bundle between draw control and rect_plotter
interface rect_plotter_if #(
    parameter int X_W  = 8,
    parameter int Y_W  = 7,
    parameter int SZ_W = 4
);
    logic            start;
    logic            abort;
    logic [X_W-1:0]  x0;
    logic [Y_W-1:0]  y0;
    logic [SZ_W-1:0] width;
    logic [SZ_W-1:0] height;
    logic [2:0]      colour_in;
    logic            outline;
    logic            busy;
    logic            done;
    logic [X_W-1:0]  x_out;
    logic [Y_W-1:0]  y_out;
    logic [2:0]      colour_out;
    logic            plot;

    modport master (
        output start, abort, x0, y0, width, height, colour_in, outline,
        input  busy, done, x_out, y_out, colour_out, plot
    );

    modport slave (
        input  start, abort, x0, y0, width, height, colour_in, outline,
        output busy, done, x_out, y_out, colour_out, plot
    );
endinterface

// File: rtl/rect_plotter.sv
// rtl/rect_plotter.sv - one-shot W x H rectangle rasteriser with outline, clipping and abort
// Emits one pixel per clock in raster order; clipped/skipped pixels still consume a cycle.
module rect_plotter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SZ_W     = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clock,
    input  logic        reset,
    rect_plotter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FIN} state_t;

    localparam logic [X_W:0]    SCR_W = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]    SCR_H = (Y_W+1)'(SCREEN_H);
    localparam logic [SZ_W-1:0] ONE   = SZ_W'(1);

    state_t          state_q;
    logic [X_W-1:0]  x0_q;
    logic [Y_W-1:0]  y0_q;
    logic [SZ_W-1:0] w_q;
    logic [SZ_W-1:0] h_q;
    logic            outline_q;
    logic [SZ_W-1:0] cx_q;
    logic [SZ_W-1:0] cy_q;
    logic            busy_q;
    logic            done_q;
    logic            plot_q;
    logic [X_W-1:0]  x_out_q;
    logic [Y_W-1:0]  y_out_q;
    logic [2:0]      colour_out_q;

    // Coordinates are one bit wider so that overflow past the screen is clipped, not wrapped.
    logic [X_W:0] px;
    logic [Y_W:0] py;
    logic         cx_last;
    logic         cy_last;
    logic         on_edge;
    logic         plot_d;

    assign px      = (X_W+1)'(x0_q) + (X_W+1)'(cx_q);
    assign py      = (Y_W+1)'(y0_q) + (Y_W+1)'(cy_q);
    assign cx_last = (cx_q == w_q - ONE);
    assign cy_last = (cy_q == h_q - ONE);
    assign on_edge = (cx_q == '0) || cx_last || (cy_q == '0) || cy_last;
    assign plot_d  = (px < SCR_W) && (py < SCR_H) && (!outline_q || on_edge);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            x0_q         <= '0;
            y0_q         <= '0;
            w_q          <= '0;
            h_q          <= '0;
            outline_q    <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            plot_q       <= 1'b0;
            x_out_q      <= '0;
            y_out_q      <= '0;
            colour_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            plot_q <= 1'b0;
            if (busy_q && bus.abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                cx_q    <= '0;
                cy_q    <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            x0_q         <= bus.x0;
                            y0_q         <= bus.y0;
                            w_q          <= bus.width;
                            h_q          <= bus.height;
                            outline_q    <= bus.outline;
                            colour_out_q <= bus.colour_in;
                            cx_q         <= '0;
                            cy_q         <= '0;
                            busy_q       <= 1'b1;
                            if (bus.width == '0 || bus.height == '0) begin
                                state_q <= S_FIN;
                            end else begin
                                state_q <= S_DRAW;
                            end
                        end
                    end
                    S_DRAW: begin
                        plot_q  <= plot_d;
                        x_out_q <= px[X_W-1:0];
                        y_out_q <= py[Y_W-1:0];
                        if (cx_last) begin
                            cx_q <= '0;
                            if (cy_last) begin
                                state_q <= S_FIN;
                            end else begin
                                cy_q <= cy_q + ONE;
                            end
                        end else begin
                            cx_q <= cx_q + ONE;
                        end
                    end
                    S_FIN: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.plot       = plot_q;
    assign bus.x_out      = x_out_q;
    assign bus.y_out      = y_out_q;
    assign bus.colour_out = colour_out_q;
endmodule

// File: doc/rect_plotter.md
# rect_plotter

Parametrised rectangle rasteriser that sits between drawing control logic and `vga_adapter`. On a `start` handshake it walks every pixel of a W×H box anchored at (x0, y0) in raster order and emits one pixel per clock on `x_out`/`y_out`/`colour_out`/`plot`. It supports filled or outline-only mode, screen-edge clipping and abort. It generalises the fixed 6×6 free-running square generator into a one-shot, sized, handshaked block.

## Interface
- `X_W`, 8, width of x coordinate
- `Y_W`, 7, width of y coordinate
- `SZ_W`, 4, width of box size fields (max size 2^SZ_W − 1 per axis)
- `SCREEN_W`, 160, pixels with x ≥ this are clipped
- `SCREEN_H`, 120, pixels with y ≥ this are clipped

Ports:
- `clock`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only when idle
- `abort`  in  1  cancel current rectangle
- `x0`  in  X_W  anchor x (top-left)
- `y0`  in  Y_W  anchor y (top-left)
- `width`  in  SZ_W  box width in pixels
- `height`  in  SZ_W  box height in pixels
- `colour_in`  in  3  pixel colour
- `outline`  in  1  1 = outline only, 0 = filled
- `busy`  out  1  rectangle in progress
- `done`  out  1  one-cycle completion pulse
- `x_out`  out  X_W  pixel x to adapter
- `y_out`  out  Y_W  pixel y to adapter
- `colour_out`  out  3  pixel colour to adapter
- `plot`  out  1  write strobe to adapter

## Operation
- States:
  - IDLE → DRAW on `start`.
  - DRAW → FIN after the last pixel.
  - FIN → IDLE unconditionally.
  - Any state → IDLE on `abort` while busy.
- In IDLE with `start`=1, latch `x0`, `y0`, `width`, `height`, `colour_in` and `outline`. Clear counters `cx`=`cy`=0. Inputs may change freely afterwards.
- If `width`==0 or `height`==0, go straight to FIN. No pixel is plotted.
- DRAW emits pixel (`cx`, `cy`) each cycle:
  - `cx` increments first.
  - At `cx`==W−1, `cx` wraps to 0 and `cy` increments.
  - The pixel at `cx`==W−1, `cy`==H−1 is the last one.
- Pixel coordinates:
  - px = x0 + cx and py = y0 + cy, each computed one bit wider than `X_W`/`Y_W`.
  - `x_out` and `y_out` take the low `X_W`/`Y_W` bits.
- `plot`=1 for a pixel only when all of the following hold:
  - px < SCREEN_W and py < SCREEN_H (no wrap-around drawing)
  - `outline`=0, or the pixel is on an edge (`cx`==0, `cx`==W−1, `cy`==0 or `cy`==H−1)
- Clipped and interior-skipped pixels still take one cycle each, so the cycle count is always W·H.
- `start` is ignored while `busy`=1.
- `abort` takes priority over `start` and the counters:
  - Next edge: `plot`=0, `busy`=0, state IDLE.
  - No `done` pulse.

## Timing
- Reset (asynchronous, immediate): state IDLE; counters 0; `busy`, `done`, `plot`, `x_out`, `y_out` and `colour_out` all 0. Reset mid-rectangle discards it with no `done`.
- All outputs are registered.
- Let E0 be the edge that accepts `start` (normal W·H > 0 case):
  - E0: `busy`←1.
  - E1 … E(W·H): register pixels 0 … W·H−1.
  - E(W·H+1): `plot`←0, `done`←1, `busy`←0, state IDLE.
  - E(W·H+2): `done`←0.
- Zero-size rectangle:
  - E0: `busy`←1.
  - E1: `done`←1, `busy`←0.
  - `plot` never rises.
- Back-to-back: `start` asserted during the `done` cycle is accepted, because the state is IDLE. The next rectangle's first pixel then appears two edges after `done` rises. There are no idle pixels between rectangles beyond the FIN cycle.
- `colour_out` holds the latched colour for the whole rectangle.

## Test plan
- Filled 3×2 at (10,20), colour 3'b101, `outline`=0:
  - Expected `plot`=1 for 6 consecutive cycles at (10,20) (11,20) (12,20) (10,21) (11,21) (12,21).
  - `done` pulses on the cycle after the last pixel.
  - `busy` high for exactly 7 cycles.
- Outline 4×4 at (0,0):
  - 16 pixel cycles.
  - `plot`=0 only at (1,1) (2,1) (1,2) (2,2); 12 plots total.
- Clip, 4×3 at (158,118):
  - `plot`=1 only for px ∈ {158,159}, py ∈ {118,119}, i.e. 4 plots.
  - Still 12 cycles, then `done`.
  - `x_out` never wraps to 0 with `plot`=1.
- Zero size (`width`=0, `height`=5):
  - `done` on E1, `plot` never asserted.
  - `start` held high through the `done` cycle starts a new rectangle.
- Abort after 3 pixels of an 8×8:
  - `plot`=0 and `busy`=0 on the next edge, `done` stays 0.
  - A `start` asserted while busy earlier was ignored.
- Asynchronous reset pulse mid-DRAW (between edges):
  - All outputs 0 immediately.
  - After release, a new 2×2 draws correctly from `cx`=`cy`=0.
